// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: TX accepts one word via valid/ready, but only when idle and without queueing; RX gives a 1-cycle valid pulse and has no buffering.
// TX START waits for the next baud tick; RX reports at the last stop-bit centre. Define UART_LOOPBACK_EN to feed the RX synchroniser from tx_out.
module uart_core_param #(
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 1,
   parameter int STOP_BITS   = 1,
   parameter int OVERSAMPLE  = 16,
   parameter int DIV_W       = 12,
   parameter logic [DIV_W-1:0] DIV0 = DIV_W'(325),
   parameter logic [DIV_W-1:0] DIV1 = DIV_W'(162),
   parameter logic [DIV_W-1:0] DIV2 = DIV_W'(54),
   parameter logic [DIV_W-1:0] DIV3 = DIV_W'(27)
) (
   input  logic                 Clk,
   input  logic                 reset,
   input  logic [1:0]           baud_sel_in,
   input  logic [DATA_BITS-1:0] tx_data_in,
   input  logic                 tx_valid_in,
   output logic                 tx_ready_out,
   output logic                 tx_out,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data_out,
   output logic                 rx_valid_out,
   output logic                 rx_parity_err_out,
   output logic                 rx_frame_err_out,
   output logic                 rx_busy_out
);
   localparam int TCW = $clog2(STOP_BITS*OVERSAMPLE + 1);
   localparam int BCW = $clog2(DATA_BITS + 1);
   localparam logic [TCW-1:0] T_BIT  = TCW'(OVERSAMPLE - 1);
   localparam logic [TCW-1:0] T_HALF = TCW'(OVERSAMPLE/2 - 1);
   localparam logic [TCW-1:0] T_STOP = TCW'(STOP_BITS*OVERSAMPLE - 1);
   localparam logic [BCW-1:0] B_LAST = BCW'(DATA_BITS - 1);
   localparam logic [BCW-1:0] B_STOP = BCW'(STOP_BITS - 1);
   localparam logic           HAS_PAR = (PARITY_MODE != 0);
   localparam logic [DIV_W-1:0] DIV0_N = (DIV0 == '0) ? DIV_W'(1) : DIV0;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   function automatic logic f_par(input logic [DATA_BITS-1:0] d);
      return (PARITY_MODE == 2) ? ~^d : ^d;
   endfunction

   state_t                 r_tx_state, r_rx_state;
   logic                   r_tx_pend, r_tx_ready, r_tx_out, r_tx_par;
   logic [DATA_BITS-1:0]   r_tx_word;
   logic [TCW-1:0]         r_tx_tcnt, r_rx_tcnt;
   logic [BCW-1:0]         r_tx_bit, r_rx_bit;
   logic [1:0]             r_sync;
   logic [DATA_BITS-1:0]   r_rx_sh, r_rx_data;
   logic                   r_rx_pbit, r_rx_facc, r_rx_valid, r_rx_perr, r_rx_ferr;
   logic [DIV_W-1:0]       w_div_sel, r_div, r_cnt;
   logic                   w_tick, w_all_idle, w_rx_src, w_rx_line;

   always_comb begin
      w_div_sel = DIV0;
      case (baud_sel_in)
         2'd0: w_div_sel = DIV0;
         2'd1: w_div_sel = DIV1;
         2'd2: w_div_sel = DIV2;
         2'd3: w_div_sel = DIV3;
         default: w_div_sel = DIV0;
      endcase
      if (w_div_sel == '0) w_div_sel = DIV_W'(1);
   end

   // Divisor only follows baud_sel_in between frames so a frame never changes speed.
   assign w_all_idle = (r_tx_state == S_IDLE) && !r_tx_pend && (r_rx_state == S_IDLE);
   assign w_tick     = (r_cnt >= r_div - DIV_W'(1));

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_div <= DIV0_N;
      end else begin
         if (w_all_idle) r_div <= w_div_sel;
         r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         r_tx_state <= S_IDLE;
         r_tx_pend  <= 1'b0;
         r_tx_ready <= 1'b1;
         r_tx_out   <= 1'b1;
         r_tx_word  <= '0;
         r_tx_par   <= 1'b0;
         r_tx_tcnt  <= '0;
         r_tx_bit   <= '0;
      end else begin
         case (r_tx_state)
            S_IDLE: begin
               if (!r_tx_pend) begin
                  if (tx_valid_in && r_tx_ready) begin
                     r_tx_word  <= tx_data_in;
                     r_tx_par   <= f_par(tx_data_in);
                     r_tx_pend  <= 1'b1;
                     r_tx_ready <= 1'b0;
                  end
               end else if (w_tick) begin
                  r_tx_pend  <= 1'b0;
                  r_tx_state <= S_START;
                  r_tx_out   <= 1'b0;
                  r_tx_tcnt  <= '0;
               end
            end
            S_START: if (w_tick) begin
               if (r_tx_tcnt == T_BIT) begin
                  r_tx_state <= S_DATA;
                  r_tx_out   <= r_tx_word[0];
                  r_tx_tcnt  <= '0;
                  r_tx_bit   <= '0;
               end else r_tx_tcnt <= r_tx_tcnt + TCW'(1);
            end
            S_DATA: if (w_tick) begin
               if (r_tx_tcnt == T_BIT) begin
                  r_tx_tcnt <= '0;
                  if (r_tx_bit == B_LAST) begin
                     r_tx_state <= HAS_PAR ? S_PARITY : S_STOP;
                     r_tx_out   <= HAS_PAR ? r_tx_par : 1'b1;
                  end else begin
                     r_tx_bit  <= r_tx_bit + BCW'(1);
                     r_tx_word <= r_tx_word >> 1;
                     r_tx_out  <= r_tx_word[1];
                  end
               end else r_tx_tcnt <= r_tx_tcnt + TCW'(1);
            end
            S_PARITY: if (w_tick) begin
               if (r_tx_tcnt == T_BIT) begin
                  r_tx_state <= S_STOP;
                  r_tx_out   <= 1'b1;
                  r_tx_tcnt  <= '0;
               end else r_tx_tcnt <= r_tx_tcnt + TCW'(1);
            end
            S_STOP: if (w_tick) begin
               if (r_tx_tcnt == T_STOP) begin
                  r_tx_state <= S_IDLE;
                  r_tx_ready <= 1'b1;
               end else r_tx_tcnt <= r_tx_tcnt + TCW'(1);
            end
            default: r_tx_state <= S_IDLE;
         endcase
      end
   end

`ifdef UART_LOOPBACK_EN
   assign w_rx_src = r_tx_out;
`else
   assign w_rx_src = rx_in;
`endif
   assign w_rx_line = r_sync[1];

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         r_sync     <= 2'b11;
         r_rx_state <= S_IDLE;
         r_rx_tcnt  <= '0;
         r_rx_bit   <= '0;
         r_rx_sh    <= '0;
         r_rx_pbit  <= 1'b0;
         r_rx_facc  <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_rx_perr  <= 1'b0;
         r_rx_ferr  <= 1'b0;
      end else begin
         r_sync     <= {r_sync[0], w_rx_src};
         r_rx_valid <= 1'b0;
         case (r_rx_state)
            S_IDLE: if (!w_rx_line) begin
               r_rx_state <= S_START;
               r_rx_tcnt  <= '0;
            end
            S_START: if (w_tick) begin
               if (r_rx_tcnt == T_HALF) begin
                  r_rx_state <= w_rx_line ? S_IDLE : S_DATA;
                  r_rx_tcnt  <= '0;
                  r_rx_bit   <= '0;
                  r_rx_facc  <= 1'b0;
               end else r_rx_tcnt <= r_rx_tcnt + TCW'(1);
            end
            S_DATA: if (w_tick) begin
               if (r_rx_tcnt == T_BIT) begin
                  r_rx_tcnt <= '0;
                  r_rx_sh   <= {w_rx_line, r_rx_sh[DATA_BITS-1:1]};
                  if (r_rx_bit == B_LAST) begin
                     r_rx_bit   <= '0;
                     r_rx_state <= HAS_PAR ? S_PARITY : S_STOP;
                  end else r_rx_bit <= r_rx_bit + BCW'(1);
               end else r_rx_tcnt <= r_rx_tcnt + TCW'(1);
            end
            S_PARITY: if (w_tick) begin
               if (r_rx_tcnt == T_BIT) begin
                  r_rx_pbit  <= w_rx_line;
                  r_rx_state <= S_STOP;
                  r_rx_tcnt  <= '0;
               end else r_rx_tcnt <= r_rx_tcnt + TCW'(1);
            end
            // Leave at the last stop-bit centre so an immediately following start edge is caught.
            S_STOP: if (w_tick) begin
               if (r_rx_tcnt == T_BIT) begin
                  r_rx_tcnt <= '0;
                  if (r_rx_bit == B_STOP) begin
                     r_rx_data  <= r_rx_sh;
                     r_rx_perr  <= HAS_PAR && (r_rx_pbit != f_par(r_rx_sh));
                     r_rx_ferr  <= r_rx_facc | ~w_rx_line;
                     r_rx_valid <= 1'b1;
                     r_rx_state <= S_IDLE;
                  end else begin
                     r_rx_facc <= r_rx_facc | ~w_rx_line;
                     r_rx_bit  <= r_rx_bit + BCW'(1);
                  end
               end else r_rx_tcnt <= r_rx_tcnt + TCW'(1);
            end
            default: r_rx_state <= S_IDLE;
         endcase
      end
   end

   assign tx_ready_out      = r_tx_ready;
   assign tx_out            = r_tx_out;
   assign rx_data_out       = r_rx_data;
   assign rx_valid_out      = r_rx_valid;
   assign rx_parity_err_out = r_rx_perr;
   assign rx_frame_err_out  = r_rx_ferr;
   assign rx_busy_out       = (r_rx_state != S_IDLE);

endmodule
